// File: rtl/inst_fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : inst_fetch_sequencer_pkg
// Brief   : Shared types and constants for the byte-serial instruction fetcher.
// Revision: 1.0
// ============================================================================
package inst_fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef logic [2:0] byte_cnt_t;

    localparam logic [31:0] c_nop_inst       = 32'h0000_0013;
    localparam int          c_bytes_per_inst = 4;

endpackage : inst_fetch_sequencer_pkg
`default_nettype wire

// File: rtl/inst_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : inst_fetch_sequencer_if
// Brief   : Memory, redirect and core handshake signals of the fetch sequencer.
// Revision: 1.0
// ============================================================================
interface inst_fetch_sequencer_if #(
    parameter int ADDR_W = 64
);
    logic              Mem_Rd_En;
    logic [ADDR_W-1:0] Byte_Address;
    logic [7:0]        Byte_Data;
    logic              Branch_Taken;
    logic [ADDR_W-1:0] Branch_Target;
    logic              Inst_Ready;
    logic              Inst_Valid;
    logic [31:0]       Instruction;
    logic [ADDR_W-1:0] Inst_PC;
    logic              Fetch_Fault;

    modport master (
        output Mem_Rd_En, Byte_Address, Inst_Valid, Instruction, Inst_PC, Fetch_Fault,
        input  Byte_Data, Branch_Taken, Branch_Target, Inst_Ready
    );

    modport slave (
        input  Mem_Rd_En, Byte_Address, Inst_Valid, Instruction, Inst_PC, Fetch_Fault,
        output Byte_Data, Branch_Taken, Branch_Target, Inst_Ready
    );
endinterface : inst_fetch_sequencer_if
`default_nettype wire

// File: rtl/inst_fetch_sequencer_assembler.sv
`default_nettype none
// ============================================================================
// Module  : inst_byte_assembler
// Brief   : Collects four little-endian bytes, indexed by the fetch counter.
// Revision: 1.0
// ============================================================================
module inst_byte_assembler
    import inst_fetch_sequencer_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_flush,
    input  wire logic        i_capture,
    input  wire byte_cnt_t   i_cnt,
    input  wire logic [7:0]  i_byte,
    output logic      [31:0] o_word
);
    logic [31:0] r_word;
    logic        w_capture_ok;
    logic [1:0]  w_lane;

    // Data for the read issued at cnt-1 arrives while cnt is current.
    assign w_capture_ok = i_capture && (i_cnt != 3'd0) && (i_cnt <= 3'd4);
    assign w_lane       = 2'(i_cnt - 3'd1);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_word <= '0;
        end else if (w_capture_ok) begin
            r_word[{w_lane, 3'b000} +: 8] <= i_byte;
        end
    end

    // Word including the byte arriving this cycle, so the top can load at cnt=4.
    always_comb begin
        o_word = r_word;
        if (w_capture_ok) begin
            o_word[{w_lane, 3'b000} +: 8] = i_byte;
        end
    end

endmodule : inst_byte_assembler
`default_nettype wire

// File: rtl/inst_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : inst_fetch_sequencer
// Brief   : Walks the PC, reads four bytes per instruction and presents the
//           assembled word to the core; handles redirects and fetch faults.
// Revision: 1.0
// ============================================================================
module inst_fetch_sequencer
    import inst_fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       MEM_BYTES = 132
) (
    input  wire logic              clk,
    input  wire logic              reset,
    inst_fetch_sequencer_if.master bus
);
    fetch_state_t      r_state, w_state_n;
    byte_cnt_t         r_cnt, w_cnt_n;
    logic [ADDR_W-1:0] r_pc, w_pc_n;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_inst_pc;
    logic [31:0]       w_word;
    logic              w_load;
    logic              w_flush;

    // Evaluated one bit wider so an address near the top of the space cannot wrap into range.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W:0] last;
        last = {1'b0, addr} + (ADDR_W+1)'(3);
        return last < (ADDR_W+1)'(MEM_BYTES);
    endfunction

    assign w_pc_plus4 = r_pc + ADDR_W'(c_bytes_per_inst);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= FETCH;
            r_cnt     <= '0;
            r_pc      <= RESET_PC;
            r_instr   <= '0;
            r_inst_pc <= RESET_PC;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_pc    <= w_pc_n;
            if (w_load) begin
                r_instr   <= w_word;
                r_inst_pc <= r_pc;
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_pc_n    = r_pc;
        w_load    = 1'b0;
        w_flush   = 1'b0;
        case (r_state)
            FAULT: begin
                w_state_n = FAULT;
            end
            default: begin
                // A redirect overrides both byte progress and a pending handshake.
                if (bus.Branch_Taken) begin
                    if ((bus.Branch_Target[1:0] != 2'b00) || !in_range(bus.Branch_Target)) begin
                        w_state_n = FAULT;
                    end else begin
                        w_pc_n    = bus.Branch_Target;
                        w_cnt_n   = '0;
                        w_flush   = 1'b1;
                        w_state_n = FETCH;
                    end
                end else if (r_state == FETCH) begin
                    if (r_cnt == 3'd4) begin
                        w_load    = 1'b1;
                        w_state_n = HOLD;
                    end else begin
                        w_cnt_n = r_cnt + 3'd1;
                    end
                end else if (bus.Inst_Ready) begin
                    w_pc_n    = w_pc_plus4;
                    w_cnt_n   = '0;
                    w_flush   = 1'b1;
                    w_state_n = in_range(w_pc_plus4) ? FETCH : FAULT;
                end
            end
        endcase
    end

    inst_byte_assembler u_assembler (
        .clk       (clk),
        .rst       (reset),
        .i_flush   (w_flush),
        .i_capture (r_state == FETCH),
        .i_cnt     (r_cnt),
        .i_byte    (bus.Byte_Data),
        .o_word    (w_word)
    );

    assign bus.Mem_Rd_En    = !reset && (r_state == FETCH) && (r_cnt < 3'd4);
    assign bus.Byte_Address = r_pc + ADDR_W'(r_cnt);
    assign bus.Inst_Valid   = (r_state == HOLD);
    assign bus.Instruction  = r_instr;
    assign bus.Inst_PC      = r_inst_pc;
    assign bus.Fetch_Fault  = (r_state == FAULT);

endmodule : inst_fetch_sequencer
`default_nettype wire

// File: tb/tb_inst_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_inst_fetch_sequencer
// Brief   : Self-checking bench: byte memory model, accept scoreboard, redirect table.
// Revision: 1.0
// ============================================================================
module tb_inst_fetch_sequencer;
    localparam int ADDR_W    = 64;
    localparam int MEM_BYTES = 132;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [63:0] target;
        logic        exp_fault;
        logic        ready;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    inst_fetch_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    inst_fetch_sequencer #(
        .ADDR_W    (ADDR_W),
        .RESET_PC  ('0),
        .MEM_BYTES (MEM_BYTES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [MEM_BYTES];
    exp_t       sb_q [$];
    vec_t       vecs [8];
    int         total = 0;
    int         bad   = 0;

    always @(posedge clk) begin
        if (bus.Mem_Rd_En) begin
            bus.Byte_Data <= (bus.Byte_Address < 64'(MEM_BYTES)) ? mem[bus.Byte_Address[7:0]] : 8'hEE;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [63:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && bus.Inst_Valid && bus.Inst_Ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_accept: got pc 0x%0h want none", bus.Inst_PC);
            end else begin
                e = sb_q.pop_front();
                chk("sb_pc", bus.Inst_PC, e.pc);
                chk("sb_instr", 64'(bus.Instruction), 64'(e.instr));
            end
        end
    end

    task automatic do_reset();
        reset              = 1'b1;
        bus.Branch_Taken   = 1'b0;
        bus.Branch_Target  = '0;
        bus.Inst_Ready     = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Expect exactly one accepted instruction at pc, within a bounded window.
    task automatic accept_one(input logic [63:0] pc);
        exp_t e;
        bit   done;
        @(posedge clk);
        #1;
        e.pc    = pc;
        e.instr = word_at(pc);
        sb_q.push_back(e);
        bus.Inst_Ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk);
            if (sb_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no accept want pc 0x%0h", pc);
            sb_q.delete();
        end
        #1 bus.Inst_Ready = 1'b0;
    endtask

    // First valid must appear exactly five cycles after the fetch starts.
    task automatic check_latency(input logic [63:0] pc);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("lat_rd_en", 64'(bus.Mem_Rd_En), 64'd1);
                chk("lat_addr", bus.Byte_Address, pc);
            end
            if (k < 5) begin
                chk("lat_valid_low", 64'(bus.Inst_Valid), 64'd0);
            end else begin
                chk("lat_valid", 64'(bus.Inst_Valid), 64'd1);
                chk("lat_instr", 64'(bus.Instruction), 64'(word_at(pc)));
                chk("lat_pc", bus.Inst_PC, pc);
            end
        end
    endtask

    initial begin
        bit found;

        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'(i * 37 + 11);
        mem[0]  = 8'h93; mem[1]  = 8'h02; mem[2]  = 8'h30; mem[3]  = 8'h00;
        mem[4]  = 8'h23; mem[5]  = 8'h32; mem[6]  = 8'h50; mem[7]  = 8'h00;
        mem[40] = 8'h63; mem[41] = 8'h0C; mem[42] = 8'h00; mem[43] = 8'h04;

        vecs[0] = '{64'h28,                  1'b0, 1'b0};
        vecs[1] = '{64'h2A,                  1'b1, 1'b0};
        vecs[2] = '{64'h80,                  1'b0, 1'b1};
        vecs[3] = '{64'h84,                  1'b1, 1'b0};
        vecs[4] = '{64'h81,                  1'b1, 1'b1};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0};
        vecs[6] = '{64'h7C,                  1'b0, 1'b1};
        vecs[7] = '{64'h2,                   1'b1, 1'b0};

        // Reset state
        reset = 1'b1;
        bus.Branch_Taken  = 1'b0;
        bus.Branch_Target = '0;
        bus.Inst_Ready    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_en", 64'(bus.Mem_Rd_En), 64'd0);
        chk("rst_valid", 64'(bus.Inst_Valid), 64'd0);
        chk("rst_instr", 64'(bus.Instruction), 64'd0);
        chk("rst_pc", bus.Inst_PC, 64'd0);
        chk("rst_fault", 64'(bus.Fetch_Fault), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // First fetch at 0 and hold while the core stalls
        check_latency(64'h0);
        chk("t1_word", 64'(bus.Instruction), 64'h0030_0293);
        repeat (3) begin
            @(negedge clk);
            chk("hold_valid", 64'(bus.Inst_Valid), 64'd1);
            chk("hold_instr", 64'(bus.Instruction), 64'h0030_0293);
            chk("hold_pc", bus.Inst_PC, 64'd0);
            chk("hold_rd_en", 64'(bus.Mem_Rd_En), 64'd0);
        end
        accept_one(64'h0);
        accept_one(64'h4);

        // Redirect mid-fetch at cnt=2
        do_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.Branch_Taken  = 1'b1;
        bus.Branch_Target = 64'h28;
        @(posedge clk); #1;
        bus.Branch_Taken  = 1'b0;
        @(negedge clk);
        chk("br_addr", bus.Byte_Address, 64'h28);
        chk("br_valid", 64'(bus.Inst_Valid), 64'd0);
        accept_one(64'h28);

        // Redirect table, issued from HOLD
        for (int v = 0; v < 8; v++) begin
            do_reset();
            found = 1'b0;
            for (int i = 0; i < 12 && !found; i++) begin
                @(posedge clk); #1;
                if (bus.Inst_Valid) found = 1'b1;
            end
            if (!found) begin
                total++;
                bad++;
                $display("FAIL vec_wait_valid: got no valid want valid (vec %0d)", v);
            end
            if (vecs[v].ready) sb_q.push_back('{64'h0, word_at(64'h0)});
            bus.Branch_Taken  = 1'b1;
            bus.Branch_Target = vecs[v].target;
            bus.Inst_Ready    = vecs[v].ready;
            @(posedge clk); #1;
            bus.Branch_Taken  = 1'b0;
            bus.Inst_Ready    = 1'b0;
            @(negedge clk);
            chk("vec_fault", 64'(bus.Fetch_Fault), 64'(vecs[v].exp_fault));
            chk("vec_valid", 64'(bus.Inst_Valid), 64'd0);
            chk("vec_rd_en", 64'(bus.Mem_Rd_En), 64'(!vecs[v].exp_fault));
            chk("vec_drained", 64'(sb_q.size()), 64'd0);
            if (!vecs[v].exp_fault) begin
                chk("vec_addr", bus.Byte_Address, vecs[v].target);
                accept_one(vecs[v].target);
            end
        end

        // Sequential walk to the last legal word, then the range fault
        do_reset();
        for (int pc = 0; pc <= 'h80; pc += 4) accept_one(64'(pc));
        @(negedge clk);
        chk("end_fault", 64'(bus.Fetch_Fault), 64'd1);
        chk("end_rd_en", 64'(bus.Mem_Rd_En), 64'd0);
        chk("end_valid", 64'(bus.Inst_Valid), 64'd0);

        // Fault is sticky against redirects and ready
        bus.Branch_Taken  = 1'b1;
        bus.Branch_Target = 64'h28;
        bus.Inst_Ready    = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("sticky_fault", 64'(bus.Fetch_Fault), 64'd1);
            chk("sticky_rd_en", 64'(bus.Mem_Rd_En), 64'd0);
            chk("sticky_valid", 64'(bus.Inst_Valid), 64'd0);
        end
        bus.Branch_Taken = 1'b0;
        bus.Inst_Ready   = 1'b0;

        // Reset at cnt=3 of a fetch at 0x28 restarts cleanly at RESET_PC
        do_reset();
        bus.Branch_Taken  = 1'b1;
        bus.Branch_Target = 64'h28;
        @(posedge clk); #1;
        bus.Branch_Taken  = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_rd_en", 64'(bus.Mem_Rd_En), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_fault", 64'(bus.Fetch_Fault), 64'd0);
        check_latency(64'h0);
        accept_one(64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_inst_fetch_sequencer
`default_nettype wire
